// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core (FETCH/DECODE/EXEC/MEM/WB) on one shared instruction/data bus.
// Latency from FETCH entry to retire: branch/NOP 3, sw 4, ALU/jal 4, lw 5 cycles, plus one per bus wait state.
// Backpressure: FETCH and MEM hold request, address and data stable until mem_ready; define MULTI_CYCLE_CORE_TRAP_EN to halt on illegal opcodes.
module multi_cycle_core #(
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] SP_INIT  = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic [31:0] pc_out,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t      state_q, state_d;
    logic [31:0] pc_q, instr_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] regs_q [32];

    // Field extraction from the latched instruction
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic        is_load, is_store, is_reg, is_imm, is_branch, is_jal, illegal;

    assign opcode    = instr_q[6:0];
    assign rd        = instr_q[11:7];
    assign f3        = instr_q[14:12];
    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign f7b5      = instr_q[30];
    assign imm_i     = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s     = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b     = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_j     = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_reg    = (opcode == OP_REG);
    assign is_imm    = (opcode == OP_IMM);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign illegal   = !(is_load || is_store || is_reg || is_imm || is_branch || is_jal);

    assign pc_out = pc_q;

    // x0 and registers beyond NUM_REGS always read as zero
    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= NUM_REGS) return 32'd0;
        return regs_q[idx];
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] op, input logic sub);
        case (op)
            3'b000:  return sub ? (x - y) : (x + y);
            3'b010:  return {31'd0, ($signed(x) < $signed(y))};
            3'b110:  return x | y;
            3'b111:  return x & y;
            default: return x + y;
        endcase
    endfunction

    function automatic logic br_taken(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        case (op)
            3'b000:  return x == y;
            3'b001:  return x != y;
            3'b100:  return $signed(x) < $signed(y);
            3'b101:  return $signed(x) >= $signed(y);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] align(input logic [31:0] v);
        return {v[31:2], 2'b00};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state and bus/retire outputs; reset gates every output combinationally
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = 32'd0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
`ifdef MULTI_CYCLE_CORE_TRAP_EN
                state_d = illegal ? S_TRAP : S_EXEC;
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_reg || is_imm || is_jal) begin
                    state_d = S_WB;
                end else begin
                    // Branches and illegal opcodes (as NOPs) retire here
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_addr  = alu_q;
                mem_we    = is_store;
                mem_wdata = is_store ? b_q : 32'd0;
                if (mem_ready) begin
                    state_d = is_store ? S_FETCH : S_WB;
                    retire  = is_store;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            state_d   = S_FETCH;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = RESET_PC;
            mem_wdata = 32'd0;
            retire    = 1'b0;
        end
    end

`ifdef MULTI_CYCLE_CORE_TRAP_EN
    assign trap = (state_q == S_TRAP) && !rst;
`else
    assign trap = 1'b0;
`endif

    // Datapath registers, PC and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            mdr_q   <= 32'd0;
            for (int i = 0; i < 32; i++) regs_q[i] <= (i == 2) ? SP_INIT : 32'd0;
        end else begin
            case (state_q)
                S_FETCH: if (mem_ready) instr_q <= mem_rdata;
                S_DECODE: begin
                    a_q <= rf_read(rs1);
                    b_q <= rf_read(rs2);
                end
                S_EXEC: begin
                    if (is_load) begin
                        alu_q <= a_q + imm_i;
                    end else if (is_store) begin
                        alu_q <= a_q + imm_s;
                    end else if (is_reg) begin
                        alu_q <= alu(a_q, b_q, f3, f7b5);
                    end else if (is_imm) begin
                        alu_q <= alu(a_q, imm_i, f3, 1'b0);
                    end else if (is_branch) begin
                        pc_q <= align(br_taken(a_q, b_q, f3) ? (pc_q + imm_b) : (pc_q + 32'd4));
                    end else if (is_jal) begin
                        pc_q  <= align(pc_q + imm_j);
                        alu_q <= pc_q + 32'd4;
                    end else begin
                        pc_q <= align(pc_q + 32'd4);
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_store) pc_q  <= align(pc_q + 32'd4);
                        else          mdr_q <= mem_rdata;
                    end
                end
                S_WB: begin
                    if (rd != 5'd0 && int'(rd) < NUM_REGS) regs_q[rd] <= is_load ? mdr_q : alu_q;
                    if (!is_jal) pc_q <= align(pc_q + 32'd4);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed bench for multi_cycle_core: a 32-register core driven step by step and a 16-register core run free.
// Register contents are observed through store transactions on the bus.
// Bus wait states are injected by holding mem_ready low.
module tb_multi_cycle_core;

    localparam int OPC_LOAD   = 7'b0000011;
    localparam int OPC_STORE  = 7'b0100011;
    localparam int OPC_REG    = 7'b0110011;
    localparam int OPC_IMM    = 7'b0010011;
    localparam int OPC_BRANCH = 7'b1100011;
    localparam int OPC_JAL    = 7'b1101111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main core
    logic        rst, mem_req, mem_we, mem_ready, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];

    multi_cycle_core dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retire(retire), .pc_out(pc_out), .trap(trap)
    );

    // 16-register core on a zero-wait bus
    logic        rst16, m16_req, m16_we, m16_retire, m16_trap;
    logic [31:0] m16_addr, m16_wdata, m16_rdata, m16_pc;
    logic        m16_ready;
    logic [31:0] mem16 [0:255];
    logic [31:0] st16 [0:7];
    int          n16;
    assign m16_ready = 1'b1;
    assign m16_rdata = mem16[m16_addr[9:2]];

    multi_cycle_core #(.NUM_REGS(16)) dut16 (
        .clk(clk), .rst(rst16), .mem_req(m16_req), .mem_we(m16_we), .mem_addr(m16_addr),
        .mem_wdata(m16_wdata), .mem_rdata(m16_rdata), .mem_ready(m16_ready),
        .retire(m16_retire), .pc_out(m16_pc), .trap(m16_trap)
    );

    always @(posedge clk) begin
        if (rst16) begin
            n16 <= 0;
        end else if (m16_req && m16_we && m16_ready) begin
            if (n16 < 8) st16[n16] <= m16_wdata;
            n16 <= n16 + 1;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPC_REG[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], OPC_STORE[6:0]};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], OPC_BRANCH[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OPC_JAL[6:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then drive mem_ready for this cycle
    task automatic cyc(input logic r);
        @(posedge clk);
        #2;
        mem_ready = r;
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    // Two reset cycles; returns in the first fetch cycle with a zero-wait bus
    task automatic restart();
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        cyc(1'b0);
        cyc(1'b0);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
    endtask

    task automatic run_to_fetch(input logic [31:0] a, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (mem_req && !mem_we && mem_addr == a) found = 1'b1;
            else cyc(1'b1);
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    // Called in a fetch cycle (counted as cycle 1); counts cycles up to the retire pulse
    task automatic lat(input int n, input string tag);
        int count = 1;
        while (!retire && count < 20) begin
            cyc(1'b1);
            count++;
        end
        chk(tag, count, n);
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            cyc(1'b1);
            if (mem_req && mem_we) found = 1'b1;
        end
        chk({tag, "_seen"}, {31'd0, found}, 32'd1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_data"}, mem_wdata, d);
    endtask

    initial begin
        rst       = 1'b1;
        rst16     = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem16[i] = 32'd0;
        mem16[0] = enc_i(1, 0, 0, 20, OPC_IMM);    // addi x20,x0,1
        mem16[1] = enc_r(0, 0, 20, 0, 5);          // add  x5,x20,x0
        mem16[2] = enc_s(32'h100, 5, 0);           // sw   x5,0x100(x0)
        mem16[3] = enc_s(32'h104, 20, 0);          // sw   x20,0x104(x0)
        mem16[4] = enc_i(9, 0, 0, 1, OPC_IMM);     // addi x1,x0,9
        mem16[5] = enc_s(32'h108, 1, 0);           // sw   x1,0x108(x0)
        mem16[6] = enc_j(0, 0);                    // jal  x0,0

        // Reset values, then addi x1,x0,5
        clear_mem();
        mem[0] = enc_i(5, 0, 0, 1, OPC_IMM);
        mem[1] = enc_s(32'h100, 1, 0);
        mem[2] = enc_j(0, 0);
        cyc(1'b0);
        cyc(1'b0);
        rst16 = 1'b0;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_retire", retire, 0);
        chk("rst_trap", trap, 0);
        chk("rst_pc", pc_out, 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("fetch0_req", mem_req, 1);
        chk("fetch0_we", mem_we, 0);
        chk("fetch0_addr", mem_addr, 0);
        cyc(1'b1);
        chk("decode_req", mem_req, 0);
        cyc(1'b1);
        chk("exec_req", mem_req, 0);
        chk("exec_retire", retire, 0);
        cyc(1'b1);
        chk("wb_req", mem_req, 0);
        chk("addi_retire_c4", retire, 1);
        cyc(1'b1);
        chk("addi_pc", pc_out, 4);
        expect_store(32'h100, 32'd5, "addi_x1");

        // sw x2,0(x0) with three wait states; then a zero-wait sw
        clear_mem();
        mem[0] = enc_s(0, 2, 0);
        mem[1] = enc_s(4, 2, 0);
        mem[2] = enc_j(0, 0);
        restart();
        cyc(1'b1);
        cyc(1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            chk("sw_wait_req", mem_req, 1);
            chk("sw_wait_we", mem_we, 1);
            chk("sw_wait_addr", mem_addr, 0);
            chk("sw_wait_wdata", mem_wdata, 255);
            chk("sw_wait_retire", retire, 0);
        end
        cyc(1'b1);
        chk("sw_done_req", mem_req, 1);
        chk("sw_done_wdata", mem_wdata, 255);
        chk("sw_done_retire", retire, 1);
        cyc(1'b1);
        chk("sw_next_pc", pc_out, 4);
        chk("sw_next_addr", mem_addr, 4);
        lat(4, "sw_lat");

        // beq taken, then bne not taken
        clear_mem();
        mem[0] = enc_i(3, 0, 0, 1, OPC_IMM);
        mem[1] = enc_i(3, 0, 0, 3, OPC_IMM);
        mem[2] = enc_j(8, 0);
        mem[4] = enc_b(-8, 3, 1, 0);
        restart();
        run_to_fetch(16, "beq_fetch");
        lat(3, "beq_lat");
        cyc(1'b1);
        chk("beq_pc", pc_out, 8);
        mem[4] = enc_b(-8, 3, 1, 1);
        mem[5] = enc_s(32'h100, 1, 0);
        mem[6] = enc_j(0, 0);
        restart();
        run_to_fetch(16, "bne_fetch");
        lat(3, "bne_lat");
        cyc(1'b1);
        chk("bne_pc", pc_out, 20);
        expect_store(32'h100, 32'd3, "bne_x1");

        // jal x1,+12 at pc 4; addi x0 is discarded
        clear_mem();
        mem[0] = enc_i(7, 0, 0, 0, OPC_IMM);
        mem[1] = enc_j(12, 1);
        mem[4] = enc_s(32'h100, 1, 0);
        mem[5] = enc_s(32'h104, 0, 0);
        mem[6] = enc_j(0, 0);
        restart();
        run_to_fetch(4, "jal_fetch");
        lat(4, "jal_lat");
        cyc(1'b1);
        chk("jal_pc", pc_out, 16);
        expect_store(32'h100, 32'd8, "jal_link");
        expect_store(32'h104, 32'd0, "x0_zero");

        // lw
        clear_mem();
        mem[0]    = enc_i(32'h100, 0, 2, 6, OPC_LOAD);
        mem[1]    = enc_s(32'h104, 6, 0);
        mem[2]    = enc_j(0, 0);
        mem[64]   = 32'hDEAD_BEEF;
        restart();
        lat(5, "lw_lat");
        expect_store(32'h104, 32'hDEAD_BEEF, "lw_data");

        // ALU operations and signed branches
        clear_mem();
        mem[0]  = enc_i(-3, 0, 0, 1, OPC_IMM);   // x1 = -3
        mem[1]  = enc_i(5, 0, 0, 3, OPC_IMM);    // x3 = 5
        mem[2]  = enc_r(7'h20, 1, 3, 0, 4);      // sub x4,x3,x1
        mem[3]  = enc_s(32'h100, 4, 0);
        mem[4]  = enc_r(0, 3, 1, 2, 4);          // slt x4,x1,x3
        mem[5]  = enc_s(32'h100, 4, 0);
        mem[6]  = enc_r(0, 3, 1, 7, 4);          // and
        mem[7]  = enc_s(32'h100, 4, 0);
        mem[8]  = enc_r(0, 3, 1, 6, 4);          // or
        mem[9]  = enc_s(32'h100, 4, 0);
        mem[10] = enc_i(-1, 3, 2, 4, OPC_IMM);   // slti x4,x3,-1
        mem[11] = enc_s(32'h100, 4, 0);
        mem[12] = enc_b(8, 3, 1, 4);             // blt x1,x3,+8 (taken)
        mem[13] = enc_s(32'h100, 3, 0);
        mem[14] = enc_b(8, 3, 1, 5);             // bge x1,x3,+8 (not taken)
        mem[15] = enc_r(0, 3, 1, 0, 4);          // add
        mem[16] = enc_s(32'h100, 4, 0);
        mem[17] = enc_i(6, 1, 7, 4, OPC_IMM);    // andi x4,x1,6
        mem[18] = enc_s(32'h100, 4, 0);
        mem[19] = enc_j(0, 0);
        restart();
        expect_store(32'h100, 32'd8, "sub");
        expect_store(32'h100, 32'd1, "slt");
        expect_store(32'h100, 32'd5, "and");
        expect_store(32'h100, 32'hFFFF_FFFD, "or");
        expect_store(32'h100, 32'd0, "slti");
        expect_store(32'h100, 32'd2, "blt_bge_add");
        expect_store(32'h100, 32'd4, "andi");

        // Unsupported opcode (lui encoding)
        clear_mem();
        mem[0] = 32'h1234_52B7;
        mem[1] = enc_s(32'h100, 5, 0);
        mem[2] = enc_j(0, 0);
        restart();
`ifdef MULTI_CYCLE_CORE_TRAP_EN
        cyc(1'b1);
        chk("trap_decode", trap, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            chk("trap_flag", trap, 1);
            chk("trap_req", mem_req, 0);
            chk("trap_retire", retire, 0);
            chk("trap_pc", pc_out, 0);
        end
        rst = 1'b1;
        #1;
        chk("trap_rst_flag", trap, 0);
        chk("trap_rst_req", mem_req, 0);
`else
        lat(3, "nop_lat");
        cyc(1'b1);
        chk("nop_pc", pc_out, 4);
        chk("nop_trap", trap, 0);
        expect_store(32'h100, 32'd0, "nop_no_write");
`endif

        // Reset during a stalled lw
        clear_mem();
        mem[0] = enc_i(32'h100, 0, 2, 6, OPC_LOAD);
        restart();
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        chk("lw_stall_req", mem_req, 1);
        chk("lw_stall_addr", mem_addr, 32'h100);
        chk("lw_stall_we", mem_we, 0);
        cyc(1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_addr", mem_addr, 0);
        cyc(1'b0);
        chk("midrst_req2", mem_req, 0);
        chk("midrst_pc", pc_out, 0);
        chk("midrst_retire", retire, 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("refetch_req", mem_req, 1);
        chk("refetch_addr", mem_addr, 0);
        chk("refetch_we", mem_we, 0);

        // 16-register core results
        chk("r16_count", n16, 3);
        chk("r16_x5", st16[0], 0);
        chk("r16_x20", st16[1], 0);
        chk("r16_x1", st16[2], 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
